// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage.
// Opcodes, funct3 codes, FSM states and beat-count helpers.
package mem_stage_pkg;

   localparam logic [6:0] LOAD_CODE  = 7'b0000011;
   localparam logic [6:0] STORE_CODE = 7'b0100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [31:0] Zero_Word    = 32'h0;
   localparam logic [4:0]  Null_RegAddr = 5'h0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_e;

   function automatic logic f3_legal(input logic st,
                                     input logic [2:0] f3);
      logic ok;
      if (st)
         ok = (f3 == F3_SB) | (f3 == F3_SH) | (f3 == F3_SW);
      else
         ok = (f3 == F3_LB) | (f3 == F3_LH) | (f3 == F3_LW) |
              (f3 == F3_LBU) | (f3 == F3_LHU);
      return ok;
   endfunction

   // Index of the final beat: 1, 2 or 4 bytes -> 0, 1 or 3.
   function automatic logic [1:0] last_beat(input logic [1:0] sz);
      return (sz == 2'd2) ? 2'd3 : sz;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide ready-handshaked memory port.
// The stage is the master; the memory is the slave.
interface mem_stage_if #(
   parameter int ADDR_W = 17
);
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [7:0]        mem_wdata_o;
   logic [7:0]        mem_rdata_i;
   logic              mem_ready_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i, mem_ready_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i, mem_ready_i
   );
endinterface

// File: rtl/mem_stage_load_ext.sv
// Load-data extension: funct3 plus assembled buffer to a
// sign- or zero-extended writeback word.
module load_ext
   import mem_stage_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] lbuf,
   output logic [31:0] ext
);

   always_comb begin
      ext = Zero_Word;
      unique case (1'b1)
         (funct3 == F3_LB):  ext = {{24{lbuf[7]}}, lbuf[7:0]};
         (funct3 == F3_LH):  ext = {{16{lbuf[15]}}, lbuf[15:0]};
         (funct3 == F3_LW):  ext = lbuf;
         (funct3 == F3_LBU): ext = {24'h0, lbuf[7:0]};
         (funct3 == F3_LHU): ext = {16'h0, lbuf[15:0]};
         default:            ext = Zero_Word;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: byte-serial loads/stores with
// stall request, zero-latency pass-through for other ops.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid_i,
   input  logic [6:0]   op_i,
   input  logic [2:0]   funct3_i,
   input  logic [31:0]  mem_addr_i,
   input  logic [31:0]  reg_i,
   input  logic [4:0]   wd_i,
   input  logic         wreg_i,
   input  logic [31:0]  wdata_i,
   mem_stage_if.master  mem,
   output logic         stallreq_o,
   output logic [4:0]   wd_o,
   output logic         wreg_o,
   output logic [31:0]  wdata_o
);

   state_e            state;
   logic [1:0]        k;
   logic [1:0]        last_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       sdata_q;
   logic              st_q;
   logic [2:0]        f3_q;
   logic [31:0]       buf_q;
   logic [31:0]       ext;

   logic is_ld;
   logic is_st;
   logic legal;
   logic acc;

   assign is_ld = valid_i & (op_i == LOAD_CODE);
   assign is_st = valid_i & (op_i == STORE_CODE);
   assign legal = (is_ld | is_st) & f3_legal(is_st, funct3_i);
   assign acc   = (state == S_ACCESS);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         k       <= 2'd0;
         last_q  <= 2'd0;
         addr_q  <= '0;
         sdata_q <= Zero_Word;
         st_q    <= 1'b0;
         f3_q    <= 3'd0;
         buf_q   <= Zero_Word;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (legal) begin
                  k       <= 2'd0;
                  last_q  <= last_beat(funct3_i[1:0]);
                  addr_q  <= mem_addr_i[ADDR_W-1:0];
                  sdata_q <= reg_i;
                  st_q    <= is_st;
                  f3_q    <= funct3_i;
                  state   <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (mem.mem_ready_i) begin
                  if (!st_q)
                     buf_q[{k, 3'b000} +: 8] <= mem.mem_rdata_i;
                  k <= k + 2'd1;
                  if (k == last_q)
                     state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Address wraps in the physical space by plain ADDR_W addition.
   assign mem.mem_req_o   = acc;
   assign mem.mem_we_o    = acc & st_q;
   assign mem.mem_addr_o  = acc ? addr_q + ADDR_W'(k) : '0;
   assign mem.mem_wdata_o = acc ? sdata_q[{k, 3'b000} +: 8] : 8'h0;

   load_ext u_ext (
      .funct3 (f3_q),
      .lbuf   (buf_q),
      .ext    (ext)
   );

   always_comb begin
      stallreq_o = 1'b0;
      wd_o       = wd_i;
      wreg_o     = wreg_i & valid_i;
      wdata_o    = wdata_i;
      unique case (state)
         S_IDLE: begin
            if (is_ld | is_st) begin
               wreg_o     = 1'b0;
               stallreq_o = legal;
            end
         end
         S_ACCESS: begin
            stallreq_o = 1'b1;
            wreg_o     = 1'b0;
         end
         S_DONE: begin
            wreg_o  = ~st_q & wreg_i;
            wdata_o = st_q ? wdata_i : ext;
         end
         default: ;
      endcase
   end

   logic unused;
   assign unused = ^{mem_addr_i[31:ADDR_W]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a byte-array memory
// that answers beats and can withhold ready on one beat.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int AW = 17;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [6:0]  op_i;
   logic [2:0]  funct3_i;
   logic [31:0] mem_addr_i;
   logic [31:0] reg_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic        stallreq_o;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;

   mem_stage_if #(.ADDR_W(AW)) m ();

   mem_stage #(.ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .op_i       (op_i),
      .funct3_i   (funct3_i),
      .mem_addr_i (mem_addr_i),
      .reg_i      (reg_i),
      .wd_i       (wd_i),
      .wreg_i     (wreg_i),
      .wdata_i    (wdata_i),
      .mem        (m),
      .stallreq_o (stallreq_o),
      .wd_o       (wd_o),
      .wreg_o     (wreg_o),
      .wdata_o    (wdata_o)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] ADD_CODE = 7'b0110011;

   logic [7:0]    mem_arr [0:(1<<AW)-1];
   logic [AW-1:0] b_addr [8];
   logic [7:0]    b_data [8];
   logic          b_we [8];
   int            nbeats;
   int            stalls;
   logic          wreg_bad;
   logic          hold_bad;
   logic [4:0]    r_wd;
   logic          r_wreg;
   logic [31:0]   r_wdata;
   logic          r_req;
   int            errors = 0;
   int            checks = 0;

   task automatic access(input string tag, input logic [6:0] op,
                         input logic [2:0] f3,
                         input logic [31:0] addr,
                         input logic [31:0] rs2,
                         input logic [4:0] wd, input logic wr,
                         input int hold_beat, input int hold_n);
      int            held;
      logic [AW-1:0] pa;
      logic [7:0]    pd;
      logic          ph;
      logic          fin;
      nbeats = 0; stalls = 0; wreg_bad = 0; hold_bad = 0;
      held = 0; ph = 0; fin = 0; pa = '0; pd = 8'h0;
      @(negedge clk);
      valid_i = 1; op_i = op; funct3_i = f3; mem_addr_i = addr;
      reg_i = rs2; wd_i = wd; wreg_i = wr; wdata_i = 32'hA5A5A5A5;
      m.mem_ready_i = 0;
      for (int c = 0; c < 40 && !fin; c++) begin
         #1;
         if (!stallreq_o) begin
            r_wd = wd_o; r_wreg = wreg_o; r_wdata = wdata_o;
            r_req = m.mem_req_o; fin = 1;
         end else begin
            stalls++;
            if (wreg_o !== 1'b0) wreg_bad = 1;
            if (ph && (m.mem_addr_o !== pa || m.mem_wdata_o !== pd))
               hold_bad = 1;
            ph = 0;
            m.mem_ready_i = 0;
            if (m.mem_req_o === 1'b1) begin
               if (nbeats == hold_beat && held < hold_n) begin
                  held++; ph = 1;
                  pa = m.mem_addr_o; pd = m.mem_wdata_o;
               end else begin
                  m.mem_ready_i = 1;
                  m.mem_rdata_i = mem_arr[m.mem_addr_o];
                  if (nbeats < 8) begin
                     b_addr[nbeats] = m.mem_addr_o;
                     b_we[nbeats]   = m.mem_we_o;
                     b_data[nbeats] = m.mem_we_o ? m.mem_wdata_o
                                                 : m.mem_rdata_i;
                  end
                  if (m.mem_we_o) mem_arr[m.mem_addr_o] = m.mem_wdata_o;
                  nbeats++;
               end
            end
            @(negedge clk);
         end
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL %s timeout: stall still high, required drop within 40 cycles", tag);
      end
      @(negedge clk);
      valid_i = 0; wreg_i = 0; m.mem_ready_i = 0;
   endtask

   task automatic test_reset();
      rst = 1; valid_i = 0; op_i = 0; funct3_i = 0; mem_addr_i = 0;
      reg_i = 0; wd_i = 0; wreg_i = 0; wdata_i = 0;
      m.mem_ready_i = 0; m.mem_rdata_i = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (m.mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", m.mem_req_o); end
      checks++; if (m.mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", m.mem_we_o); end
      checks++; if (m.mem_addr_o !== '0) begin errors++; $display("FAIL rst_addr got %h want 0", m.mem_addr_o); end
      checks++; if (m.mem_wdata_o !== 8'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", m.mem_wdata_o); end
      checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stallreq_o); end
      checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL rst_wreg got %b want 0", wreg_o); end
      checks++; if (wdata_o !== 32'h0) begin errors++; $display("FAIL rst_wdata_o got %h want 0", wdata_o); end
      @(negedge clk); rst = 0;
   endtask

   task automatic test_lw();
      logic [AW-1:0] ea;
      mem_arr[17'h100] = 8'h11; mem_arr[17'h101] = 8'h22;
      mem_arr[17'h102] = 8'h33; mem_arr[17'h103] = 8'h44;
      access("lw", LOAD_CODE, F3_LW, 32'h100, 32'h0, 5'd5, 1'b1, -1, 0);
      checks++; if (nbeats != 4) begin errors++; $display("FAIL lw_beats got %0d want 4", nbeats); end
      for (int i = 0; i < 4; i++) begin
         ea = AW'(17'h100 + i);
         checks++;
         if (b_addr[i] !== ea || b_we[i] !== 1'b0) begin
            errors++;
            $display("FAIL lw_beat%0d got addr %h we %b want %h we 0", i, b_addr[i], b_we[i], ea);
         end
      end
      checks++; if (r_wdata !== 32'h44332211) begin errors++; $display("FAIL lw_data got %h want 44332211", r_wdata); end
      checks++; if (r_wreg !== 1'b1 || r_wd !== 5'd5) begin errors++; $display("FAIL lw_wb got wreg %b wd %0d want 1 5", r_wreg, r_wd); end
      checks++; if (stalls != 5) begin errors++; $display("FAIL lw_stall got %0d want 5", stalls); end
      checks++; if (wreg_bad !== 1'b0) begin errors++; $display("FAIL lw_wreg_stall got 1 want 0"); end
   endtask

   task automatic test_ext();
      mem_arr[17'h20] = 8'h80;
      mem_arr[17'h30] = 8'h00; mem_arr[17'h31] = 8'h80;
      access("lb", LOAD_CODE, F3_LB, 32'h20, 32'h0, 5'd6, 1'b1, -1, 0);
      checks++; if (r_wdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got %h want ffffff80", r_wdata); end
      checks++; if (stalls != 2) begin errors++; $display("FAIL lb_stall got %0d want 2", stalls); end
      access("lbu", LOAD_CODE, F3_LBU, 32'h20, 32'h0, 5'd6, 1'b1, -1, 0);
      checks++; if (r_wdata !== 32'h00000080) begin errors++; $display("FAIL lbu got %h want 00000080", r_wdata); end
      access("lh", LOAD_CODE, F3_LH, 32'h30, 32'h0, 5'd7, 1'b1, -1, 0);
      checks++; if (r_wdata !== 32'hFFFF8000) begin errors++; $display("FAIL lh got %h want ffff8000", r_wdata); end
      access("lhu", LOAD_CODE, F3_LHU, 32'h30, 32'h0, 5'd7, 1'b1, -1, 0);
      checks++; if (r_wdata !== 32'h00008000) begin errors++; $display("FAIL lhu got %h want 00008000", r_wdata); end
   endtask

   task automatic test_sh_wrap();
      access("sh", STORE_CODE, F3_SH, 32'h1FFFF, 32'hDEADBEEF, 5'd9, 1'b1, -1, 0);
      checks++; if (nbeats != 2) begin errors++; $display("FAIL sh_beats got %0d want 2", nbeats); end
      checks++;
      if (b_addr[0] !== 17'h1FFFF || b_data[0] !== 8'hEF || b_we[0] !== 1'b1) begin
         errors++; $display("FAIL sh_beat0 got %h@%h we %b want ef@1ffff we 1", b_data[0], b_addr[0], b_we[0]);
      end
      checks++;
      if (b_addr[1] !== 17'h00000 || b_data[1] !== 8'hBE || b_we[1] !== 1'b1) begin
         errors++; $display("FAIL sh_beat1 got %h@%h we %b want be@00000 we 1", b_data[1], b_addr[1], b_we[1]);
      end
      checks++; if (wreg_bad !== 1'b0 || r_wreg !== 1'b0) begin errors++; $display("FAIL sh_wreg got stall %b done %b want 0 0", wreg_bad, r_wreg); end
   endtask

   task automatic test_sw_hold();
      access("sw", STORE_CODE, F3_SW, 32'h200, 32'h01234567, 5'd0, 1'b0, 1, 3);
      checks++; if (stalls != 8) begin errors++; $display("FAIL sw_stall got %0d want 8", stalls); end
      checks++; if (hold_bad !== 1'b0) begin errors++; $display("FAIL sw_hold got unstable want stable"); end
      checks++;
      if ({mem_arr[17'h203], mem_arr[17'h202], mem_arr[17'h201], mem_arr[17'h200]} !== 32'h01234567) begin
         errors++;
         $display("FAIL sw_mem got %h%h%h%h want 01234567", mem_arr[17'h203], mem_arr[17'h202], mem_arr[17'h201], mem_arr[17'h200]);
      end
   endtask

   task automatic test_passthrough();
      logic req_seen;
      @(negedge clk);
      valid_i = 1; op_i = ADD_CODE; funct3_i = 3'd0; wd_i = 5'd3;
      wreg_i = 1; wdata_i = 32'h7;
      #1;
      checks++; if (wdata_o !== 32'h7 || wreg_o !== 1'b1 || wd_o !== 5'd3) begin
         errors++; $display("FAIL pass got %h/%b/%0d want 7/1/3", wdata_o, wreg_o, wd_o);
      end
      checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL pass_stall got %b want 0", stallreq_o); end
      req_seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         if (m.mem_req_o !== 1'b0) req_seen = 1;
      end
      checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL pass_req got 1 want 0"); end
      valid_i = 0; #1;
      checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL invalid_wreg got %b want 0", wreg_o); end
   endtask

   task automatic test_illegal();
      access("ld3", LOAD_CODE, 3'd3, 32'h100, 32'h0, 5'd4, 1'b1, -1, 0);
      checks++; if (stalls != 0 || nbeats != 0 || r_req !== 1'b0) begin
         errors++; $display("FAIL ld3 got stall %0d beats %0d want 0 0", stalls, nbeats);
      end
      checks++; if (r_wreg !== 1'b0) begin errors++; $display("FAIL ld3_wreg got %b want 0", r_wreg); end
      access("st4", STORE_CODE, 3'd4, 32'h100, 32'h0, 5'd4, 1'b1, -1, 0);
      checks++; if (stalls != 0 || nbeats != 0 || r_wreg !== 1'b0) begin
         errors++; $display("FAIL st4 got stall %0d beats %0d wreg %b want 0 0 0", stalls, nbeats, r_wreg);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      valid_i = 1; op_i = LOAD_CODE; funct3_i = F3_LW;
      mem_addr_i = 32'h300; wd_i = 5'd8; wreg_i = 1;
      m.mem_ready_i = 1; m.mem_rdata_i = 8'h5A;
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++; if (m.mem_req_o !== 1'b1 || m.mem_addr_o !== 17'h301) begin
         errors++; $display("FAIL mid_beat2 got req %b addr %h want 1 301", m.mem_req_o, m.mem_addr_o);
      end
      @(negedge clk);
      rst = 1; valid_i = 0; wreg_i = 0;
      @(posedge clk);
      #1;
      checks++; if (m.mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
         errors++; $display("FAIL mid_rst got req %b stall %b want 0 0", m.mem_req_o, stallreq_o);
      end
      @(negedge clk);
      rst = 0; m.mem_ready_i = 0;
      access("lw_after", LOAD_CODE, F3_LW, 32'h100, 32'h0, 5'd5, 1'b1, -1, 0);
      checks++; if (r_wdata !== 32'h44332211 || stalls != 5) begin
         errors++; $display("FAIL lw_after got %h stall %0d want 44332211 5", r_wdata, stalls);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_ext();
      test_sh_wrap();
      test_sw_hold();
      test_passthrough();
      test_illegal();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
